// File: rtl/multicycle_controller.sv
// multicycle_controller
// Control unit of the multicycle accumulator CPU. Sequences fetch, decode,
// execute and write-back of the 1-byte register ops and the 3-byte memory
// format (LDA/STA/JMP/JZ/JC) by driving every datapath strobe and select.
// Optional feature macro: CU_HALT_EN (opcode 1001 enters a sticky HALT state;
// when undefined, 1001 decodes as NOP and `halted` is tied low).
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] IrToCU,
  input  logic [2:0] CznToCU,
  output logic       pcInc,
  output logic       pcLoadEn,
  output logic       diLoadEn,
  output logic       irWriteEn,
  output logic       trWriteEn,
  output logic       bRegWriteEn,
  output logic       aRegWriteEn,
  output logic       aluResWriteEn,
  output logic       ldCZN,
  output logic       accumulatorWriteEn,
  output logic       memoryWriteEn,
  output logic       PcOrTR,
  output logic       regOrMem,
  output logic       RegBOr0,
  output logic       RegAOr0,
  output logic [1:0] accAddressSel,
  output logic [1:0] aluOpControl,
  output logic       halted
);

  typedef enum logic [3:0] {
    FETCH1,
    DECODE,
    RDA,
    EXEC,
    WB,
    FETCH2,
    FETCH3,
    MEMX,
    MV,
    LD3,
    ST3
`ifdef CU_HALT_EN
    , HALT
`endif
  } stateT;

  // IR[7:5] codes of the 3-byte memory format
  localparam logic [2:0] OP_LDA = 3'b000;
  localparam logic [2:0] OP_STA = 3'b001;
  localparam logic [2:0] OP_JMP = 3'b010;
  localparam logic [2:0] OP_JZ  = 3'b011;
  localparam logic [2:0] OP_JC  = 3'b101;

  stateT      state;
  logic [2:0] op_q;   // memory-format opcode, kept because byte2 overwrites IR
  logic [1:0] alu_q;  // reg-op ALU function, held for EXEC

  logic isRegOp;
  logic isMemFmt;

  // The N flag is not consumed by any branch condition.
  logic unusedFlagN;
  assign unusedFlagN = CznToCU[2];

  // Opcode classification from IR[7:5]/IR[7:6]; 100x is the NOP/HALT group
  always_comb begin
    isRegOp  = (IrToCU[3:2] == 2'b11);
    isMemFmt = !isRegOp && (IrToCU[3:1] != 3'b100);
  end

  // Instruction sequencer: state register plus the opcode/ALU latches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH1;
      op_q  <= 3'b000;
      alu_q <= 2'b00;
    end else begin
      case (state)
        FETCH1: state <= DECODE;
        DECODE: begin
          if (isRegOp) begin
            alu_q <= IrToCU[1:0];
            state <= RDA;
          end else if (isMemFmt) begin
            op_q  <= IrToCU[3:1];
            state <= FETCH2;
          end else begin
            state <= FETCH1;
`ifdef CU_HALT_EN
            if (IrToCU == 4'b1001) state <= HALT;
`endif
          end
        end
        RDA:    state <= EXEC;
        EXEC:   state <= WB;
        WB:     state <= FETCH1;
        FETCH2: state <= FETCH3;
        FETCH3: state <= MEMX;
        MEMX: begin
          if (op_q == OP_LDA || op_q == OP_STA) state <= MV;
          else                                  state <= FETCH1;
        end
        MV:     state <= (op_q == OP_LDA) ? LD3 : ST3;
        LD3:    state <= FETCH1;
        ST3:    state <= FETCH1;
`ifdef CU_HALT_EN
        HALT:   state <= HALT;
`endif
        default: state <= FETCH1;
      endcase
    end
  end

  // Moore decode of the registered state; only the MEMX branch looks at flags.
  // While reset is asserted every output sits at its default.
  always_comb begin
    pcInc              = 1'b0;
    pcLoadEn           = 1'b0;
    diLoadEn           = 1'b0;
    irWriteEn          = 1'b0;
    trWriteEn          = 1'b0;
    bRegWriteEn        = 1'b0;
    aRegWriteEn        = 1'b0;
    aluResWriteEn      = 1'b0;
    ldCZN              = 1'b0;
    accumulatorWriteEn = 1'b0;
    memoryWriteEn      = 1'b0;
    PcOrTR             = 1'b1;
    regOrMem           = 1'b0;
    RegBOr0            = 1'b0;
    RegAOr0            = 1'b0;
    accAddressSel      = 2'b00;
    aluOpControl       = 2'b00;
    halted             = 1'b0;
    if (rst) begin
      case (state)
        FETCH1: begin
          irWriteEn = 1'b1;
          pcInc     = 1'b1;
        end
        DECODE: begin
          if (isRegOp) begin
            accAddressSel = 2'b01;
            regOrMem      = 1'b1;
            bRegWriteEn   = 1'b1;
          end else if (isMemFmt) begin
            diLoadEn = 1'b1;
          end
        end
        RDA: begin
          accAddressSel = 2'b10;
          aRegWriteEn   = 1'b1;
        end
        EXEC: begin
          aluOpControl  = alu_q;
          aluResWriteEn = 1'b1;
          ldCZN         = 1'b1;
        end
        WB: begin
          accAddressSel      = 2'b01;
          accumulatorWriteEn = 1'b1;
        end
        FETCH2: begin
          irWriteEn = 1'b1;
          pcInc     = 1'b1;
        end
        FETCH3: begin
          trWriteEn = 1'b1;
          pcInc     = 1'b1;
        end
        MEMX: begin
          case (op_q)
            OP_JMP: pcLoadEn = 1'b1;
            OP_JZ:  pcLoadEn = CznToCU[1];
            OP_JC:  pcLoadEn = CznToCU[0];
            OP_LDA: begin
              PcOrTR      = 1'b0;
              regOrMem    = 1'b0;
              bRegWriteEn = 1'b1;
            end
            OP_STA: begin
              accAddressSel = 2'b00;
              regOrMem      = 1'b1;
              bRegWriteEn   = 1'b1;
            end
            default: ;
          endcase
        end
        MV: begin
          RegAOr0       = 1'b1;
          aluOpControl  = 2'b00;
          aluResWriteEn = 1'b1;
        end
        LD3: begin
          accAddressSel      = 2'b00;
          accumulatorWriteEn = 1'b1;
        end
        ST3: begin
          PcOrTR        = 1'b0;
          memoryWriteEn = 1'b1;
        end
`ifdef CU_HALT_EN
        HALT: halted = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
// Directed bench: a small behavioural datapath (memory, PC, IR/DI/TR, A/B,
// ALU result, register file, flags) is driven by the controller so that
// instruction-level results can be checked alongside per-cycle strobes.
// Honours CU_HALT_EN for the 0x90 expectations.
module tb_multicycle_controller;

  logic       clk;
  logic       rst;
  logic [3:0] IrToCU;
  logic [2:0] CznToCU;
  logic pcInc, pcLoadEn, diLoadEn, irWriteEn, trWriteEn;
  logic bRegWriteEn, aRegWriteEn, aluResWriteEn, ldCZN;
  logic accumulatorWriteEn, memoryWriteEn;
  logic PcOrTR, regOrMem, RegBOr0, RegAOr0;
  logic [1:0] accAddressSel, aluOpControl;
  logic halted;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .IrToCU(IrToCU), .CznToCU(CznToCU),
    .pcInc(pcInc), .pcLoadEn(pcLoadEn), .diLoadEn(diLoadEn),
    .irWriteEn(irWriteEn), .trWriteEn(trWriteEn),
    .bRegWriteEn(bRegWriteEn), .aRegWriteEn(aRegWriteEn),
    .aluResWriteEn(aluResWriteEn), .ldCZN(ldCZN),
    .accumulatorWriteEn(accumulatorWriteEn), .memoryWriteEn(memoryWriteEn),
    .PcOrTR(PcOrTR), .regOrMem(regOrMem), .RegBOr0(RegBOr0), .RegAOr0(RegAOr0),
    .accAddressSel(accAddressSel), .aluOpControl(aluOpControl), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of every control output
  localparam logic [19:0] PCI   = 20'd1 << 19;
  localparam logic [19:0] PCL   = 20'd1 << 18;
  localparam logic [19:0] DIL   = 20'd1 << 17;
  localparam logic [19:0] IRW   = 20'd1 << 16;
  localparam logic [19:0] TRW   = 20'd1 << 15;
  localparam logic [19:0] BRW   = 20'd1 << 14;
  localparam logic [19:0] ARW   = 20'd1 << 13;
  localparam logic [19:0] ARES  = 20'd1 << 12;
  localparam logic [19:0] LDF   = 20'd1 << 11;
  localparam logic [19:0] ACCW  = 20'd1 << 10;
  localparam logic [19:0] MEMW  = 20'd1 << 9;
  localparam logic [19:0] PCTR  = 20'd1 << 8;
  localparam logic [19:0] ROM   = 20'd1 << 7;
  localparam logic [19:0] B0    = 20'd1 << 6;
  localparam logic [19:0] A0    = 20'd1 << 5;
  localparam logic [19:0] SEL01 = 20'd1 << 3;
  localparam logic [19:0] SEL10 = 20'd2 << 3;
  localparam logic [19:0] OPSUB = 20'd1 << 1;
  localparam logic [19:0] HLT   = 20'd1;
  localparam logic [19:0] F1VEC = PCI | IRW | PCTR;

  logic [19:0] ctl;
  assign ctl = {pcInc, pcLoadEn, diLoadEn, irWriteEn, trWriteEn, bRegWriteEn,
                aRegWriteEn, aluResWriteEn, ldCZN, accumulatorWriteEn,
                memoryWriteEn, PcOrTR, regOrMem, RegBOr0, RegAOr0,
                accAddressSel, aluOpControl, halted};

  // ---------------- behavioural datapath ----------------
  logic [7:0]  mem [0:8191];
  logic [7:0]  rf  [0:3];
  logic [12:0] pc;
  logic [7:0]  ir, di, tr, aReg, bReg, res;
  logic [2:0]  czn;
  logic [12:0] memAddr;
  logic [7:0]  memData;
  logic [1:0]  accIdx;
  logic [7:0]  opA, opB;
  logic [8:0]  aluWide;

  // Test setup image, applied while progLoad is high
  logic        progLoad;
  logic [12:0] imgAddr [0:15];
  logic [7:0]  imgData [0:15];
  int          imgN;
  logic [12:0] presetPc;
  logic [7:0]  presetRf [0:3];
  logic [2:0]  presetCzn;

  assign IrToCU  = ir[7:4];
  assign CznToCU = czn;

  always_comb begin
    memAddr = PcOrTR ? pc : {ir[4:0], tr};
    memData = mem[memAddr];
    case (accAddressSel)
      2'b00:   accIdx = di[4:3];
      2'b01:   accIdx = ir[3:2];
      2'b10:   accIdx = ir[1:0];
      default: accIdx = 2'b00;
    endcase
    opA = RegAOr0 ? 8'h00 : aReg;
    opB = RegBOr0 ? 8'h00 : bReg;
    case (aluOpControl)
      2'b00:   aluWide = {1'b0, opB} + {1'b0, opA};
      2'b01:   aluWide = {1'b0, opB} - {1'b0, opA};
      2'b10:   aluWide = {1'b0, opB & opA};
      default: aluWide = {1'b0, opB};
    endcase
  end

  always @(posedge clk) begin
    if (progLoad) begin
      for (int i = 0; i < 16; i++)
        if (i < imgN) mem[imgAddr[i]] <= imgData[i];
      for (int r = 0; r < 4; r++) rf[r] <= presetRf[r];
      pc  <= presetPc;
      czn <= presetCzn;
      ir  <= 8'h00;
    end else if (rst) begin
      if (irWriteEn)          ir <= memData;
      if (trWriteEn)          tr <= memData;
      if (diLoadEn)           di <= ir;
      if (pcInc)              pc <= pc + 13'd1;
      if (pcLoadEn)           pc <= {ir[4:0], tr};
      if (bRegWriteEn)        bReg <= regOrMem ? rf[accIdx] : memData;
      if (aRegWriteEn)        aReg <= rf[accIdx];
      if (aluResWriteEn)      res <= aluWide[7:0];
      if (ldCZN)              czn <= {aluWide[7], aluWide[7:0] == 8'h00, aluWide[8]};
      if (accumulatorWriteEn) rf[accIdx] <= res;
      if (memoryWriteEn)      mem[memAddr] <= res;
    end
  end

  // ---------------- checking ----------------
  int total;
  int bad;
  logic [19:0] expSeq [0:9];

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clearImg();
    imgN = 0;
  endtask

  task automatic putByte(input logic [12:0] addr, input logic [7:0] data);
    imgAddr[imgN] = addr;
    imgData[imgN] = data;
    imgN++;
  endtask

  task automatic setPreset(input logic [12:0] p, input logic [7:0] r0, input logic [7:0] r1,
                           input logic [7:0] r2, input logic [7:0] r3, input logic [2:0] f);
    presetPc    = p;
    presetRf[0] = r0;
    presetRf[1] = r1;
    presetRf[2] = r2;
    presetRf[3] = r3;
    presetCzn   = f;
  endtask

  // Loads the image, checks the outputs held in reset, then releases reset;
  // returns sampling inside the first FETCH1 cycle.
  task automatic doReset(input string name);
    rst      = 1'b0;
    progLoad = 1'b1;
    @(posedge clk);
    #1;
    progLoad = 1'b0;
    checkEq({name, "_rstOut"}, {12'd0, ctl}, {12'd0, PCTR});
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  // Compares n consecutive cycles against expSeq; ends in cycle n.
  task automatic runSeq(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      checkEq($sformatf("%s_c%0d", name, i + 1), {12'd0, ctl}, {12'd0, expSeq[i]});
      if (i < n - 1) begin
        @(negedge clk);
        #1;
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    progLoad = 1'b0;
    total = 0;
    bad = 0;
    imgN = 0;

    // Reg op 0xD6: SUB R1 <- R1 - R2 with 5, 3
    clearImg();
    putByte(13'h000, 8'hD6);
    putByte(13'h001, 8'h80);
    setPreset(13'h000, 8'h00, 8'h05, 8'h03, 8'h00, 3'b111);
    doReset("regop");
    expSeq[0] = F1VEC;
    expSeq[1] = BRW | SEL01 | ROM | PCTR;
    expSeq[2] = ARW | SEL10 | PCTR;
    expSeq[3] = ARES | LDF | OPSUB | PCTR;
    expSeq[4] = ACCW | SEL01 | PCTR;
    expSeq[5] = F1VEC;
    runSeq("regop", 6);
    checkEq("regop_R1", {24'd0, rf[1]}, 32'h02);
    checkEq("regop_pc", {19'd0, pc}, 32'h001);
    checkEq("regop_czn", {29'd0, czn}, 32'h0);
    $display("txn regop 0xD6: R1=%h pc=%h czn=%b", rf[1], pc, czn);

    // Reset pulse during EXEC of the same instruction
    setPreset(13'h000, 8'h00, 8'h05, 8'h03, 8'h00, 3'b000);
    doReset("rstMid");
    runSeq("rstMid", 4);
    rst = 1'b0;
    #1;
    checkEq("rstMid_inReset", {12'd0, ctl}, {12'd0, PCTR});
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkEq("rstMid_afterRel", {12'd0, ctl}, {12'd0, F1VEC});
    checkEq("rstMid_R1kept", {24'd0, rf[1]}, 32'h05);
    $display("txn reset-during-EXEC: ctl=%h R1=%h", ctl, rf[1]);

    // LDA R1, 0x040 with M[0x040]=0x7F
    clearImg();
    putByte(13'h100, 8'h08);
    putByte(13'h101, 8'h00);
    putByte(13'h102, 8'h40);
    putByte(13'h103, 8'h80);
    putByte(13'h040, 8'h7F);
    setPreset(13'h100, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000);
    doReset("lda");
    expSeq[0] = F1VEC;
    expSeq[1] = DIL | PCTR;
    expSeq[2] = F1VEC;
    expSeq[3] = PCI | TRW | PCTR;
    expSeq[4] = BRW;
    expSeq[5] = ARES | A0 | PCTR;
    expSeq[6] = ACCW | PCTR;
    expSeq[7] = F1VEC;
    runSeq("lda", 8);
    checkEq("lda_R1", {24'd0, rf[1]}, 32'h7F);
    checkEq("lda_pc", {19'd0, pc}, 32'h103);
    checkEq("lda_czn", {29'd0, czn}, 32'h0);
    $display("txn LDA 08 00 40: R1=%h pc=%h", rf[1], pc);

    // STA R2, 0x123 with R2=0xA5
    clearImg();
    putByte(13'h200, 8'h30);
    putByte(13'h201, 8'h01);
    putByte(13'h202, 8'h23);
    putByte(13'h203, 8'h80);
    putByte(13'h123, 8'h00);
    setPreset(13'h200, 8'h00, 8'h00, 8'hA5, 8'h00, 3'b000);
    doReset("sta");
    expSeq[0] = F1VEC;
    expSeq[1] = DIL | PCTR;
    expSeq[2] = F1VEC;
    expSeq[3] = PCI | TRW | PCTR;
    expSeq[4] = BRW | ROM | PCTR;
    expSeq[5] = ARES | A0 | PCTR;
    expSeq[6] = MEMW;
    expSeq[7] = F1VEC;
    runSeq("sta", 8);
    checkEq("sta_mem", {24'd0, mem[13'h123]}, 32'hA5);
    checkEq("sta_pc", {19'd0, pc}, 32'h203);
    $display("txn STA 30 01 23: M[123]=%h pc=%h", mem[13'h123], pc);

    // JZ 0x010, taken (Z=1) then not taken (Z=0)
    for (int t = 0; t < 2; t++) begin
      clearImg();
      putByte(13'h300, 8'h60);
      putByte(13'h301, 8'h00);
      putByte(13'h302, 8'h10);
      putByte(13'h303, 8'h80);
      putByte(13'h010, 8'h80);
      setPreset(13'h300, 8'h00, 8'h00, 8'h00, 8'h00, (t == 0) ? 3'b010 : 3'b101);
      doReset(t == 0 ? "jzT" : "jzN");
      expSeq[0] = F1VEC;
      expSeq[1] = DIL | PCTR;
      expSeq[2] = F1VEC;
      expSeq[3] = PCI | TRW | PCTR;
      expSeq[4] = (t == 0) ? (PCL | PCTR) : PCTR;
      expSeq[5] = F1VEC;
      runSeq(t == 0 ? "jzT" : "jzN", 6);
      checkEq(t == 0 ? "jzT_pc" : "jzN_pc", {19'd0, pc}, (t == 0) ? 32'h010 : 32'h303);
      $display("txn JZ 60 00 10 (Z=%0d): pc=%h", (t == 0) ? 1 : 0, pc);
    end

    // 0x90: HALT when enabled, otherwise a 2-cycle NOP
    clearImg();
    putByte(13'h400, 8'h90);
    putByte(13'h401, 8'h80);
    setPreset(13'h400, 8'h00, 8'h00, 8'h00, 8'h00, 3'b000);
    doReset("x90");
    expSeq[0] = F1VEC;
    expSeq[1] = PCTR;
`ifdef CU_HALT_EN
    expSeq[2] = PCTR | HLT;
    runSeq("halt", 3);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      checkEq($sformatf("halt_hold%0d", c), {12'd0, ctl}, {12'd0, PCTR | HLT});
    end
    checkEq("halt_pc", {19'd0, pc}, 32'h401);
    $display("txn HALT 0x90: halted=%b pc=%h", halted, pc);
`else
    expSeq[2] = F1VEC;
    runSeq("nop90", 3);
    checkEq("nop90_pc", {19'd0, pc}, 32'h401);
    $display("txn 0x90 as NOP: pc=%h", pc);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
